// File: rtl/div_op_sequencer_pkg.sv
// Shared definitions for the divider front-end: FSM state encoding and the
// quotient fill value returned for a divide-by-zero.
package div_op_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESULT = 2'd3
  } seq_state_e;

  // Wide all-ones pattern; users take the low WIDTH bits.
  localparam logic [63:0] DBZ_QUOT_FILL = '1;

endpackage

// File: rtl/div_op_sequencer_watchdog.sv
// Cycle counter for the WAIT phase; flags expiry on the TIMEOUT-th counted cycle.
module div_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CMAX = '1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && (cnt_q != CMAX)) begin
      // Saturate instead of wrapping so a stuck enable can never re-arm expiry.
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expire = i_en && (cnt_q == LAST);

endmodule

// File: rtl/div_op_sequencer.sv
// Front-end for the restoring divider: accepts operands, launches the divider,
// waits for done (with watchdog) and hands back quotient/remainder.
module div_op_sequencer
  import div_op_sequencer_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_dividend,
  input  logic [WIDTH-1:0] s_divisor,
  output logic             o_start,
  output logic [WIDTH-1:0] o_dividend,
  output logic [WIDTH-1:0] o_divisor,
  input  logic             i_done,
  input  logic [WIDTH-1:0] i_quotient,
  input  logic [WIDTH-1:0] i_remainder,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_quotient,
  output logic [WIDTH-1:0] m_remainder,
  output logic             m_dbz,
  output logic             m_timeout,
  output logic [1:0]       o_state
);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             tmo_q, tmo_d;
  logic             wd_clr, wd_en, wd_expire;

  div_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (wd_clr),
    .i_en     (wd_en),
    .o_expire (wd_expire)
  );

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dbz_d      = dbz_q;
    tmo_d      = tmo_q;
    wd_clr     = 1'b0;
    wd_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_valid) begin
          dividend_d = s_dividend;
          divisor_d  = s_divisor;
          dbz_d      = 1'b0;
          tmo_d      = 1'b0;
          if (s_divisor == '0) begin
            // Divide-by-zero never reaches the divider.
            quot_d  = DBZ_QUOT_FILL[WIDTH-1:0];
            rem_d   = s_dividend;
            dbz_d   = 1'b1;
            state_d = ST_RESULT;
          end else begin
            state_d = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: begin
        wd_clr  = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wd_en = 1'b1;
        // done takes priority over a coincident watchdog expiry
        if (i_done) begin
          quot_d  = i_quotient;
          rem_d   = i_remainder;
          state_d = ST_RESULT;
        end else if (wd_expire) begin
          quot_d  = '0;
          rem_d   = '0;
          tmo_d   = 1'b1;
          state_d = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (m_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dbz_q      <= dbz_d;
      tmo_q      <= tmo_d;
    end
  end

  assign s_ready     = (state_q == ST_IDLE) && !i_rst;
  assign o_start     = (state_q == ST_LAUNCH) && !i_rst;
  assign m_valid     = (state_q == ST_RESULT) && !i_rst;
  assign o_dividend  = dividend_q;
  assign o_divisor   = divisor_q;
  assign m_quotient  = quot_q;
  assign m_remainder = rem_q;
  assign m_dbz       = dbz_q;
  assign m_timeout   = tmo_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_div_op_sequencer.sv
// Randomized bench for div_op_sequencer with a behavioural divider and result model.
module tb_div_op_sequencer;

  localparam int W  = 4;
  localparam int TO = 16;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_dividend;
  logic [W-1:0] s_divisor;
  logic         o_start;
  logic [W-1:0] o_dividend;
  logic [W-1:0] o_divisor;
  logic         i_done;
  logic [W-1:0] i_quotient;
  logic [W-1:0] i_remainder;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_quotient;
  logic [W-1:0] m_remainder;
  logic         m_dbz;
  logic         m_timeout;
  logic [1:0]   o_state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 i_clk = ~i_clk;

  div_op_sequencer #(
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_dividend  (s_dividend),
    .s_divisor   (s_divisor),
    .o_start     (o_start),
    .o_dividend  (o_dividend),
    .o_divisor   (o_divisor),
    .i_done      (i_done),
    .i_quotient  (i_quotient),
    .i_remainder (i_remainder),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_quotient  (m_quotient),
    .m_remainder (m_remainder),
    .m_dbz       (m_dbz),
    .m_timeout   (m_timeout),
    .o_state     (o_state)
  );

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Expected outcome from the operation rules: k is the WAIT cycle (1-based)
  // in which the divider raises done, 0 meaning it never does.
  task automatic ref_result(input logic [W-1:0] a, input logic [W-1:0] b, input int k,
                            output logic [W-1:0] q, output logic [W-1:0] r,
                            output logic dbz, output logic tmo, output int waits);
    dbz = 1'b0; tmo = 1'b0; waits = 0;
    if (b == 0) begin
      q = '1; r = a; dbz = 1'b1;
    end else if (k >= 1 && k <= TO) begin
      q = a / b; r = a % b; waits = k;
    end else begin
      q = '0; r = '0; tmo = 1'b1; waits = TO;
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int k, input int hold);
    logic [W-1:0] eq, er;
    logic         edbz, eto;
    int           ew, w;
    ref_result(a, b, k, eq, er, edbz, eto, ew);
    w = 0;
    while (!s_ready && w < 8) begin
      step();
      w++;
    end
    chk_val("s_ready_idle", 32'(s_ready), 32'd1);
    s_valid = 1'b1; s_dividend = a; s_divisor = b;
    step();
    s_valid = 1'b0; s_dividend = W'($urandom); s_divisor = W'($urandom);
    chk_val("latch_dividend", 32'(o_dividend), 32'(a));
    chk_val("latch_divisor", 32'(o_divisor), 32'(b));
    if (b == 0) begin
      chk_val("dbz_no_start", 32'(o_start), 32'd0);
      chk_val("dbz_valid_next", 32'(m_valid), 32'd1);
    end else begin
      chk_val("launch_start", 32'(o_start), 32'd1);
      step();
      w = 1;
      while (!m_valid && w <= TO + 2) begin
        chk_val("single_start", 32'(o_start), 32'd0);
        chk_val("hold_operands", 32'({o_dividend, o_divisor}), 32'({a, b}));
        i_done      = (w == k);
        i_quotient  = (w == k) ? a / b : W'($urandom);
        i_remainder = (w == k) ? a % b : W'($urandom);
        step();
        w++;
      end
      i_done = 1'b0;
      chk_val("wait_cycles", 32'(w - 1), 32'(ew));
    end
    chk_val("res_valid", 32'(m_valid), 32'd1);
    chk_val("res_quot", 32'(m_quotient), 32'(eq));
    chk_val("res_rem", 32'(m_remainder), 32'(er));
    chk_val("res_dbz", 32'(m_dbz), 32'(edbz));
    chk_val("res_tmo", 32'(m_timeout), 32'(eto));
    chk_val("res_no_accept", 32'(s_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      i_done = 1'($urandom); i_quotient = W'($urandom); i_remainder = W'($urandom);
      step();
      chk_val("stall_valid", 32'(m_valid), 32'd1);
      chk_val("stall_result", 32'({m_quotient, m_remainder, m_dbz, m_timeout}),
              32'({eq, er, edbz, eto}));
      chk_val("stall_no_accept", 32'(s_ready), 32'd0);
      chk_val("stall_state", 32'(o_state), 32'd3);
    end
    i_done = 1'b0;
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk_val("drain_valid", 32'(m_valid), 32'd0);
    chk_val("drain_ready", 32'(s_ready), 32'd1);
    chk_val("drain_state", 32'(o_state), 32'd0);
    chk_val("drain_operands", 32'({o_dividend, o_divisor}), 32'({a, b}));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int           rk, sel;
    i_rst = 1'b1; s_valid = 1'b0; s_dividend = '0; s_divisor = '0;
    i_done = 1'b0; i_quotient = '0; i_remainder = '0; m_ready = 1'b0;
    step();
    step();
    chk_val("rst_s_ready", 32'(s_ready), 32'd0);
    chk_val("rst_state", 32'(o_state), 32'd0);
    chk_val("rst_outputs", 32'({o_start, m_valid, o_dividend, o_divisor, m_quotient,
                                m_remainder, m_dbz, m_timeout}), 32'd0);
    i_rst = 1'b0;
    #1;
    chk_val("post_rst_ready", 32'(s_ready), 32'd1);

    run_op(4'd13, 4'd3, 6, 0);
    run_op(4'd9, 4'd0, 0, 1);
    run_op(4'd15, 4'd4, 3, 5);
    run_op(4'd11, 4'd5, 0, 1);
    run_op(4'd14, 4'd3, TO, 1);
    run_op(4'd7, 4'd7, 1, 0);

    // Reset in the middle of WAIT, then a late done from the divider.
    s_valid = 1'b1; s_dividend = 4'd7; s_divisor = 4'd2;
    step();
    s_valid = 1'b0;
    step();
    step();
    chk_val("pre_rst_wait", 32'(o_state), 32'd2);
    i_rst = 1'b1;
    #1;
    chk_val("rst_hi_ready", 32'(s_ready), 32'd0);
    step();
    i_rst = 1'b0;
    #1;
    chk_val("midrst_state", 32'(o_state), 32'd0);
    chk_val("midrst_outputs", 32'({o_start, m_valid, o_dividend, o_divisor, m_quotient,
                                   m_remainder, m_dbz, m_timeout}), 32'd0);
    for (int i = 0; i < 4; i++) begin
      i_done = 1'b1; i_quotient = 4'd3; i_remainder = 4'd1;
      step();
      chk_val("late_done_valid", 32'(m_valid), 32'd0);
      chk_val("late_done_state", 32'(o_state), 32'd0);
    end
    i_done = 1'b0;

    for (int n = 0; n < 40; n++) begin
      ra  = W'($urandom);
      rb  = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0)      rk = 0;
      else if (sel == 1) rk = TO;
      else if (sel == 2) rk = TO + 1;
      else               rk = $urandom_range(1, 8);
      run_op(ra, rb, rk, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_op_sequencer.md
Name: div_op_sequencer

Overview:
Upstream front-end for the unsigned restoring divider. It accepts operand pairs over a valid/ready handshake and registers them so they stay stable on the divider's data_in inputs. It issues a one-cycle start, waits for done, then returns quotient/remainder over a second valid/ready handshake. Divide-by-zero bypasses the divider; a watchdog covers a missing done.

Parameters:
WIDTH, 4, operand/result width (matches divider WIDTH1)
TIMEOUT, 16, max cycles in WAIT before abandoning the operation (>=2)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous reset, active-high
s_valid  in  1  operand pair valid
s_ready  out  1  sequencer can accept operands
s_dividend  in  WIDTH  dividend
s_divisor  in  WIDTH  divisor
o_start  out  1  start pulse to divider
o_dividend  out  WIDTH  registered dividend to divider data_in_2
o_divisor  out  WIDTH  registered divisor to divider data_in_1
i_done  in  1  divider done
i_quotient  in  WIDTH  divider o_reg_Q
i_remainder  in  WIDTH  divider o_reg_R
m_valid  out  1  result valid
m_ready  in  1  consumer accepts result
m_quotient  out  WIDTH  result quotient
m_remainder  out  WIDTH  result remainder
m_dbz  out  1  result is divide-by-zero
m_timeout  out  1  result is watchdog timeout
o_state  out  2  current FSM state (debug)

Behaviour:
- Reset (i_rst high at an edge): state=IDLE; all registered outputs cleared (o_dividend, o_divisor, m_quotient, m_remainder, m_dbz, m_timeout = 0). o_start=0, m_valid=0, and s_ready=0 while i_rst is high.
- States: IDLE=0, LAUNCH=1, WAIT=2, RESULT=3. o_state reflects the registered state.
- s_ready = (state==IDLE) && !i_rst. m_valid = (state==RESULT). o_start = (state==LAUNCH).
- IDLE: on s_valid&&s_ready:
  - latch s_dividend→o_dividend and s_divisor→o_divisor.
  - Clear m_dbz/m_timeout.
  - If s_divisor==0: m_quotient={WIDTH{1}}, m_remainder=s_dividend, m_dbz=1, next state RESULT; the divider is not started.
  - Otherwise next state LAUNCH.
- LAUNCH: exactly one cycle; o_start=1; watchdog counter cleared; next state WAIT.
- WAIT:
  - Counter increments each cycle.
  - i_done high: capture i_quotient/i_remainder into m_quotient/m_remainder, next state RESULT.
  - Else if counter==TIMEOUT-1: m_quotient=0, m_remainder=0, m_timeout=1, next state RESULT.
  - If done and timeout coincide, done wins.
- RESULT: m_* held stable while m_ready is low. On m_ready, next state IDLE. No new operand is accepted in the same cycle.
- i_done is ignored in IDLE, LAUNCH and RESULT, so a stale or level done from the previous operation cannot complete a new one.
- o_dividend and o_divisor are constant from the accept edge until the next accept.
- Latency:
  - Accept at edge N: o_start high in cycle N+1, WAIT from N+2.
  - done sampled at edge K: m_valid high from cycle K+1.
  - dbz: m_valid high the cycle after accept.
- Reset mid-operation: return to IDLE and drop m_valid. The divider is not reset by this block; its later done is ignored.
- Watchdog counter width: $clog2(TIMEOUT)+1, no wrap.

Decomposition:
- Shared package: state encoding constants (ST_IDLE..ST_RESULT), and the dbz quotient constant (all ones of WIDTH).
- Watchdog counter is a natural sub-module: div_watchdog (clear, enable, expire at TIMEOUT-1).
- FSM and datapath registers stay in div_op_sequencer.

Test Plan:
- 13/3, divider model raises done 6 cycles after start with Q=4,R=1 -> exactly one o_start pulse, o_dividend=13 and o_divisor=3 held; m_valid with Q=4,R=1, dbz=0, timeout=0.
- 9/0 -> no o_start; m_valid the cycle after accept; Q=4'hF, R=9, dbz=1.
- 15/4 with m_ready low for 5 cycles -> m_valid, Q=3, R=3 stable and s_ready=0 throughout; m_ready high -> IDLE, s_ready=1 next cycle.
- No done from divider, TIMEOUT=16 -> m_valid after 16 WAIT cycles; Q=0, R=0, m_timeout=1.
- i_rst pulsed in WAIT -> IDLE next cycle, all outputs 0; a later i_done from the model produces no m_valid.
- i_done forced high in IDLE/RESULT -> no state change. i_done asserted on the same cycle the counter hits TIMEOUT-1 -> divider result returned, m_timeout=0.
